// File: rtl/audrey_pkg.sv
// Shared widths and state encoding for the audrey synth voice datapath.
package audrey_pkg;

    localparam int NUM_VOICES = 4;
    localparam int SAMPLE_W   = 8;
    localparam int ENV_W      = 8;
    localparam int MIX_W      = 16;
    localparam int VOL_W      = 4;
    localparam int ACC_W      = 11;
    localparam int IDX_W      = $clog2(NUM_VOICES);
    localparam int SCALE_W    = 18;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SCALE,
        OUT
    } mixer_state_t;

endpackage

// File: rtl/voice_scale.sv
// Per-voice amplitude scaling: signed sample times unsigned envelope,
// floored back to sample width by an arithmetic shift.
module voice_scale
    import audrey_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] osc,
    input  logic        [ENV_W-1:0]    env,
    output logic signed [SAMPLE_W-1:0] term
);

    localparam int PROD_W = SAMPLE_W + ENV_W;

    logic signed [PROD_W-1:0] osc_ext;
    logic signed [PROD_W-1:0] env_ext;
    logic signed [PROD_W-1:0] product;

    // Envelope is zero-extended so it always acts as a non-negative gain.
    assign osc_ext = PROD_W'(osc);
    assign env_ext = $signed(PROD_W'(env));
    assign product = osc_ext * env_ext;
    assign term    = SAMPLE_W'(product >>> ENV_W);

endmodule

// File: rtl/voice_mixer.sv
// Four-voice mixer: one pass per sample strobe, voices accumulated serially
// through a single voice_scale, then master volume with saturation.
module voice_mixer
    import audrey_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 sample_strobe,
    input  logic [NUM_VOICES-1:0][SAMPLE_W-1:0]  osc_in,
    input  logic [NUM_VOICES-1:0][ENV_W-1:0]     env_in,
    input  logic [NUM_VOICES-1:0]                voice_en,
    input  logic [VOL_W-1:0]                     master_vol,
    output logic signed [MIX_W-1:0]              mix_out,
    output logic                                 mix_valid,
    output logic                                 busy,
    output logic                                 overrun
);

    localparam logic signed [SCALE_W-1:0] SAT_MAX = SCALE_W'(32767);
    localparam logic signed [SCALE_W-1:0] SAT_MIN = -SCALE_W'(32768);

    mixer_state_t state;
    mixer_state_t next_state;

    logic [NUM_VOICES-1:0][SAMPLE_W-1:0] osc_q;
    logic [NUM_VOICES-1:0][ENV_W-1:0]    env_q;
    logic [NUM_VOICES-1:0]               en_q;
    logic [VOL_W-1:0]                    vol_q;
    logic signed [ACC_W-1:0]             acc;
    logic [IDX_W-1:0]                    voice_idx;

    logic signed [SAMPLE_W-1:0] cur_term;
    logic signed [ACC_W-1:0]    add_term;
    logic signed [SCALE_W-1:0]  acc_ext;
    logic signed [SCALE_W-1:0]  vol_ext;
    logic signed [SCALE_W-1:0]  scaled;
    logic signed [MIX_W-1:0]    sat_val;

    voice_scale u_voice_scale (
        .osc  ($signed(osc_q[voice_idx])),
        .env  (env_q[voice_idx]),
        .term (cur_term)
    );

    assign add_term = en_q[voice_idx] ? ACC_W'(cur_term) : '0;

    // Master volume times eight; the wide intermediate keeps the clamp exact.
    assign acc_ext = SCALE_W'(acc);
    assign vol_ext = $signed(SCALE_W'(vol_q));
    assign scaled  = (acc_ext * vol_ext) <<< 3;

    always_comb begin
        sat_val = MIX_W'(scaled);
        if (scaled > SAT_MAX) begin
            sat_val = MIX_W'(SAT_MAX);
        end else if (scaled < SAT_MIN) begin
            sat_val = MIX_W'(SAT_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sample_strobe) next_state = MAC;
            MAC:     if (voice_idx == IDX_W'(NUM_VOICES - 1)) next_state = SCALE;
            SCALE:   next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mix_valid = (state == OUT);
    end

    // Datapath works only from the snapshot so mid-pass input changes are harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            osc_q     <= '0;
            env_q     <= '0;
            en_q      <= '0;
            vol_q     <= '0;
            acc       <= '0;
            voice_idx <= '0;
            mix_out   <= '0;
            overrun   <= 1'b0;
        end else begin
            if (sample_strobe && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_strobe) begin
                        osc_q     <= osc_in;
                        env_q     <= env_in;
                        en_q      <= voice_en;
                        vol_q     <= master_vol;
                        acc       <= '0;
                        voice_idx <= '0;
                    end
                end
                MAC: begin
                    acc       <= acc + add_term;
                    voice_idx <= voice_idx + IDX_W'(1);
                end
                SCALE: begin
                    mix_out <= sat_val;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: directed corner cases plus random
// passes compared against an arithmetic reference model.
module tb_voice_mixer;

    logic              clk;
    logic              rst_n;
    logic              sample_strobe;
    logic [3:0][7:0]   osc_in;
    logic [3:0][7:0]   env_in;
    logic [3:0]        voice_en;
    logic [3:0]        master_vol;
    logic signed [15:0] mix_out;
    logic              mix_valid;
    logic              busy;
    logic              overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    voice_mixer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_strobe (sample_strobe),
        .osc_in        (osc_in),
        .env_in        (env_in),
        .voice_en      (voice_en),
        .master_vol    (master_vol),
        .mix_out       (mix_out),
        .mix_valid     (mix_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference mix: floor(osc*env/256) per enabled voice, summed, times vol*8, clamped.
    function automatic int modelMix(input logic [31:0] osc_v, input logic [31:0] env_v,
                                    input logic [3:0] en, input logic [3:0] vol);
        int sum = 0;
        int r;
        for (int v = 0; v < 4; v++) begin
            int o = int'($signed(osc_v[v*8 +: 8]));
            int e = int'(env_v[v*8 +: 8]);
            if (en[v]) sum += (o * e) >>> 8;
        end
        r = sum * int'(vol) * 8;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] osc_v, input logic [31:0] env_v,
                                 input logic [3:0] en, input logic [3:0] vol);
        osc_in     = osc_v;
        env_in     = env_v;
        voice_en   = en;
        master_vol = vol;
    endtask

    task automatic randomizeInputs();
        applyStimulus($urandom, $urandom, 4'($urandom), 4'($urandom));
    endtask

    // Strobe in the current cycle T, then watch cycles T+1..T+9 for the valid pulse.
    task automatic doPass(input string tag, input int expected, input bit scramble,
                          input int extra_strobe);
        int valid_cnt = 0;
        int valid_at  = -1;
        logic signed [15:0] seen = '0;
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 1) checkOutput({tag, "_busy"}, 32'(busy), 1);
            if (scramble && k == 2) randomizeInputs();
            if (mix_valid === 1'b1) begin
                valid_cnt++;
                valid_at = k;
                seen     = mix_out;
            end
            sample_strobe = (k == extra_strobe);
            tick();
        end
        sample_strobe = 1'b0;
        checkOutput({tag, "_valid_count"}, valid_cnt, 1);
        checkOutput({tag, "_valid_cycle"}, valid_at, 6);
        checkOutput({tag, "_mix"}, 32'(seen), expected);
        checkOutput({tag, "_hold"}, 32'(mix_out), expected);
        checkOutput({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int exp_mix;
        int valid_cnt;

        rst_n         = 1'b0;
        sample_strobe = 1'b0;
        applyStimulus('0, '0, '0, '0);
        tick();
        tick();
        tick();
        checkOutput("reset_mix", 32'(mix_out), 0);
        checkOutput("reset_valid", 32'(mix_valid), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        tick();

        // Single loud voice; other voices carry noise but are disabled.
        applyStimulus({$urandom} & 32'hFFFF_FF00 | 32'h0000_007F,
                      {$urandom} & 32'hFFFF_FF00 | 32'h0000_00FF, 4'b0001, 4'd8);
        doPass("single_voice", 8064, 1'b0, 0);

        applyStimulus({4{8'h80}}, {4{8'hFF}}, 4'b1111, 4'd15);
        doPass("sat_neg", -32768, 1'b0, 0);

        applyStimulus({4{8'h7F}}, {4{8'hFF}}, 4'b1111, 4'd15);
        doPass("sat_pos", 32767, 1'b0, 0);

        master_vol = 4'd0;
        doPass("vol_zero", 0, 1'b0, 0);

        applyStimulus(32'h0000_00FF, 32'h0000_0001, 4'b0001, 4'd1);
        doPass("floor", -8, 1'b0, 0);

        applyStimulus($urandom, 32'h0, 4'b1111, 4'd15);
        doPass("env_zero", 0, 1'b0, 0);

        // Extra strobes during MAC and OUT are ignored; inputs scrambled mid-pass.
        applyStimulus(32'h0000_0064, 32'h0000_00C8, 4'b0001, 4'd3);
        exp_mix = modelMix(32'h0000_0064, 32'h0000_00C8, 4'b0001, 4'd3);
        doPass("overrun_mac", exp_mix, 1'b1, 3);
        checkOutput("overrun_set", 32'(overrun), 1);
        applyStimulus(32'h0000_0064, 32'h0000_00C8, 4'b0001, 4'd3);
        doPass("overrun_out", exp_mix, 1'b0, 6);
        checkOutput("overrun_sticky", 32'(overrun), 1);

        // Reset two cycles into a pass aborts it and clears everything.
        valid_cnt = 0;
        applyStimulus({4{8'h7F}}, {4{8'hFF}}, 4'b1111, 4'd2);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        tick();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (mix_valid === 1'b1) valid_cnt++;
            tick();
        end
        checkOutput("abort_no_valid", valid_cnt, 0);
        checkOutput("abort_mix", 32'(mix_out), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        exp_mix = modelMix({4{8'h7F}}, {4{8'hFF}}, 4'b1111, 4'd2);
        doPass("post_reset", exp_mix, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            randomizeInputs();
            exp_mix = modelMix(osc_in, env_in, voice_en, master_vol);
            doPass($sformatf("rand%0d", i), exp_mix, 1'b1, 0);
        end
        checkOutput("rand_no_overrun", 32'(overrun), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
